// File: rtl/pwm_duty_slew.sv
// rtl/pwm_duty_slew.sv - duty-cycle slew limiter feeding the PWM duty input
// Optional target synchronizer enabled by DUTY_SLEW_SYNC_EN.
module pwm_duty_slew #(
    parameter int DUTY_W = 4,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DUTY_W-1:0] target,
    input  logic [RATE_W-1:0] rate,
    input  logic              period_start,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              step
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [RATE_W-1:0] icnt;
    logic [DUTY_W-1:0] target_s;
    logic [DUTY_W-1:0] next_duty;

`ifdef DUTY_SLEW_SYNC_EN
    logic [DUTY_W-1:0] sync_q1;
    logic [DUTY_W-1:0] sync_q2;

    // Free-running: ena must not stall the view of the switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= target;
            sync_q2 <= sync_q1;
        end
    end

    assign target_s = sync_q2;
`else
    assign target_s = target;
`endif

    // Only used while duty != target_s, so the +/-1 can never wrap.
    always_comb begin
        next_duty = duty;
        if (target_s > duty)
            next_duty = duty + 1'b1;
        else if (target_s < duty)
            next_duty = duty - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            icnt  <= '0;
            duty  <= '0;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (target_s != duty) begin
                            state <= WAIT;
                            icnt  <= rate;
                        end
                    end
                    WAIT: begin
                        if (target_s == duty) begin
                            state <= IDLE;
                        end else if (period_start) begin
                            if (icnt == '0) begin
                                duty <= next_duty;
                                icnt <= rate;
                                step <= 1'b1;
                                if (next_duty == target_s)
                                    state <= IDLE;
                            end else begin
                                icnt <= icnt - 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == WAIT);

endmodule

// File: tb/tb_pwm_duty_slew.sv
// tb/tb_pwm_duty_slew.sv - self-checking bench for pwm_duty_slew
// Honours DUTY_SLEW_SYNC_EN to match the build under test.
module tb_pwm_duty_slew;

`ifdef DUTY_SLEW_SYNC_EN
    localparam bit SYNC = 1'b1;
    localparam int LAT  = 3;
`else
    localparam bit SYNC = 1'b0;
    localparam int LAT  = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [3:0] target = 4'd0;
    logic [3:0] rate = 4'd0;
    logic       period_start = 1'b0;
    logic [3:0] duty;
    logic       busy;
    logic       step;

    pwm_duty_slew #(.DUTY_W(4), .RATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .target(target), .rate(rate),
        .period_start(period_start), .duty(duty), .busy(busy), .step(step)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    // Reference: counts strobes seen while a move is pending; a step fires
    // once rate+1 strobes have accumulated since entry or the last step.
    int m_duty = 0;
    bit m_wait = 0;
    int m_strobes = 0;
    int m_need = 1;
    bit m_step = 0;
    int m_s1 = 0;
    int m_s2 = 0;

    int  pcnt = 0;
    int  pper = 8;
    bit  rand_ps = 0;
    int  wait_strobes = 0;
    int  step_duties[$];
    int  step_at[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int ts;
        m_step = 0;
        if (!rst_n) begin
            m_duty = 0; m_wait = 0; m_strobes = 0; m_need = 1; m_s1 = 0; m_s2 = 0;
            return;
        end
        ts = SYNC ? m_s2 : int'(target);
        if (ena) begin
            if (!m_wait) begin
                if (ts != m_duty) begin
                    m_wait = 1; m_strobes = 0; m_need = int'(rate) + 1;
                end
            end else if (ts == m_duty) begin
                m_wait = 0;
            end else if (period_start) begin
                m_strobes++;
                if (m_strobes == m_need) begin
                    m_duty = (ts > m_duty) ? m_duty + 1 : m_duty - 1;
                    m_step = 1;
                    m_strobes = 0;
                    m_need = int'(rate) + 1;
                    if (m_duty == ts) m_wait = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = int'(target);
    endtask

    task automatic cycle();
        bit was_wait;
        period_start = rand_ps ? ($urandom_range(0, 2) == 0) : (pcnt == 0);
        was_wait = m_wait;
        if (period_start && was_wait && ena) wait_strobes++;
        model_update();
        @(posedge clk);
        #1;
        pcnt = (pcnt + 1) % pper;
        check("duty", duty, m_duty);
        check("busy", busy, m_wait);
        check("step", step, m_step);
        if (step) begin
            step_duties.push_back(int'(duty));
            step_at.push_back(wait_strobes);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        pcnt = 1;
        wait_strobes = 0;
        step_duties.delete();
        step_at.delete();
    endtask

    initial begin
        int n;
        int mx;
        bit hit;
        int exp_up[5] = '{1, 2, 3, 4, 5};
        int exp_at[3] = '{3, 6, 9};
        int exp_dn[4] = '{5, 4, 3, 2};

        // Reset with a nonzero target pending
        target = 4'd9;
        rst_n = 1'b0;
        #1;
        repeat (3) cycle();
        check("reset_duty", duty, 0);
        check("reset_busy", busy, 0);
        check("reset_step", step, 0);
        rst_n = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            cycle();
            n++;
        end
        check("busy_latency", n, LAT);

        // Ramp up, rate 0
        do_reset();
        target = 4'd5; rate = 4'd0; pper = 8;
        repeat (70) cycle();
        check("up_nsteps", step_duties.size(), 5);
        for (int i = 0; i < 5 && i < step_duties.size(); i++)
            check("up_seq", step_duties[i], exp_up[i]);
        check("up_final", duty, 5);
        check("up_busy", busy, 0);

        // Slow ramp, rate 2
        do_reset();
        target = 4'd3; rate = 4'd2; pper = 4;
        repeat (60) cycle();
        check("slow_nsteps", step_at.size(), 3);
        for (int i = 0; i < 3 && i < step_at.size(); i++)
            check("slow_strobe", step_at[i], exp_at[i]);
        check("slow_final", duty, 3);

        // Reversal mid-ramp
        do_reset();
        target = 4'd15; rate = 4'd0; pper = 8;
        hit = 0;
        for (int i = 0; i < 120 && !hit; i++) begin
            cycle();
            if (step && duty == 4'd6) hit = 1;
        end
        check("rev_reach6", hit, 1);
        target = 4'd2;
        step_duties.delete();
        mx = 0;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (int'(duty) > mx) mx = int'(duty);
        end
        check("rev_no_overshoot", (mx <= 6), 1);
        check("rev_nsteps", step_duties.size(), 4);
        for (int i = 0; i < 4 && i < step_duties.size(); i++)
            check("rev_seq", step_duties[i], exp_dn[i]);
        check("rev_final", duty, 2);

        // Freeze with ena low, then resume
        do_reset();
        target = 4'd8; rate = 4'd1; pper = 4;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cycle();
            if (step && duty == 4'd4) hit = 1;
        end
        check("frz_reach4", hit, 1);
        ena = 1'b0;
        repeat (20) cycle();
        check("frz_hold", duty, 4);
        check("frz_busy", busy, 1);
        ena = 1'b1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cycle();
            if (duty == 4'd5) hit = 1;
        end
        check("frz_resume", hit, 1);

        // Asynchronous reset mid-ramp, checked before any clock edge
        repeat (3) cycle();
        rst_n = 1'b0;
        #2;
        check("async_duty", duty, 0);
        check("async_busy", busy, 0);
        check("async_step", step, 0);
        cycle();
        rst_n = 1'b1;

        // Random targets, rates, enables and strobes against the model
        rand_ps = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) begin
                target = 4'($urandom_range(0, 15));
                rate = 4'($urandom_range(0, 3));
            end
            ena = ($urandom_range(0, 7) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
